// File: rtl/id_issue_stage.sv
// id_issue_stage -- MIPS decode/issue stage feeding the execute-stage ALU.
//
// Decodes ADDIU, ADDU, JR, LW, SW and NOP from fetch (valid/ready), reads a
// local 32x32 register file written from the write-back port (write-first
// bypass, r0 hardwired to zero), and registers the operand/control bundle in
// an ID/EX pipeline register. Load-use hazards insert LOAD_USE_BUBBLES bubbles.
//
// Ports:
//   clk, rst_n           clock (rising edge), async active-low reset
//   if_valid/if_instr    instruction from fetch; if_ready accepts it
//   wb_en/wb_addr/wb_data register file write-back
//   ex_ready             execute accepts the ID/EX register
//   ex_valid, ex_op1, ex_op2, ex_opcode, ex_ar_op, ex_shamt, ex_rd,
//   ex_wr_en, ex_mem_rd, ex_mem_wr, ex_store_data   ID/EX bundle
//   jr_taken/jr_target   one-cycle JR pulse and its rs value
//   illegal              only with DECODE_ILLEGAL_TRAP_EN: pulses when an
//                        illegal encoding is accepted (it is then not issued)
//
// Build option: define DECODE_ILLEGAL_TRAP_EN to trap illegal encodings;
// otherwise they are issued as NOP.

module id_issue_stage #(
  parameter int unsigned LOAD_USE_BUBBLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_valid,
  input  logic [31:0] if_instr,
  output logic        if_ready,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        ex_ready,
  output logic        ex_valid,
  output logic [31:0] ex_op1,
  output logic [31:0] ex_op2,
  output logic [5:0]  ex_opcode,
  output logic [5:0]  ex_ar_op,
  output logic [4:0]  ex_shamt,
  output logic [4:0]  ex_rd,
  output logic        ex_wr_en,
  output logic        ex_mem_rd,
  output logic        ex_mem_wr,
  output logic [31:0] ex_store_data,
  output logic        jr_taken,
  output logic [31:0] jr_target
`ifdef DECODE_ILLEGAL_TRAP_EN
  ,
  output logic        illegal
`endif
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [1:0] BUB_LOAD = 2'(LOAD_USE_BUBBLES - 1);

  // Instruction fields
  logic [5:0] f_opcode;
  logic [5:0] f_funct;
  logic [4:0] f_rs;
  logic [4:0] f_rt;
  logic [4:0] f_rd;

  assign f_opcode = if_instr[31:26];
  assign f_funct  = if_instr[5:0];
  assign f_rs     = if_instr[25:21];
  assign f_rt     = if_instr[20:16];
  assign f_rd     = if_instr[15:11];

  logic is_addiu, is_lw, is_sw, is_addu, is_jr;

  assign is_addiu = (f_opcode == OP_ADDIU);
  assign is_lw    = (f_opcode == OP_LW);
  assign is_sw    = (f_opcode == OP_SW);
  assign is_addu  = (f_opcode == OP_RTYPE) && (f_funct == FN_ADDU);
  assign is_jr    = (f_opcode == OP_RTYPE) && (f_funct == FN_JR);

`ifdef DECODE_ILLEGAL_TRAP_EN
  logic is_legal;
  assign is_legal = is_addiu | is_lw | is_sw | is_addu | is_jr | (if_instr == '0);
`endif

  // Register file
  logic [31:0] rf_q [32];
  logic [31:0] rf_d [32];

  always_comb begin
    for (int unsigned i = 0; i < 32; i++) begin
      rf_d[i] = rf_q[i];
    end
    if (wb_en && (wb_addr != '0)) begin
      rf_d[wb_addr] = wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 32; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 32; i++) begin
        rf_q[i] <= rf_d[i];
      end
    end
  end

  // Write-first read ports
  logic [31:0] rs_val;
  logic [31:0] rt_val;

  always_comb begin
    rs_val = '0;
    if (f_rs != '0) begin
      rs_val = (wb_en && (wb_addr == f_rs)) ? wb_data : rf_q[f_rs];
    end
    rt_val = '0;
    if (f_rt != '0) begin
      rt_val = (wb_en && (wb_addr == f_rt)) ? wb_data : rf_q[f_rt];
    end
  end

  // Decoded bundle; NOP and unrecognised encodings leave it all-zero
  logic [31:0] dec_op1, dec_op2, dec_store;
  logic [5:0]  dec_opcode, dec_ar_op;
  logic [4:0]  dec_shamt, dec_rd;
  logic        dec_wr_en, dec_mem_rd, dec_mem_wr;

  always_comb begin
    dec_op1    = '0;
    dec_op2    = '0;
    dec_store  = '0;
    dec_opcode = '0;
    dec_ar_op  = '0;
    dec_shamt  = '0;
    dec_rd     = '0;
    dec_wr_en  = 1'b0;
    dec_mem_rd = 1'b0;
    dec_mem_wr = 1'b0;
    if (is_addu || is_jr) begin
      dec_op1    = rs_val;
      dec_op2    = rt_val;
      dec_opcode = f_opcode;
      dec_ar_op  = f_funct;
      dec_shamt  = if_instr[10:6];
      dec_rd     = is_addu ? f_rd : '0;
      dec_wr_en  = is_addu;
    end else if (is_addiu || is_lw || is_sw) begin
      dec_op1    = rs_val;
      dec_op2    = {{16{if_instr[15]}}, if_instr[15:0]};
      dec_opcode = f_opcode;
      dec_shamt  = if_instr[10:6];
      dec_rd     = is_sw ? '0 : f_rt;
      dec_wr_en  = ~is_sw;
      dec_mem_rd = is_lw;
      dec_mem_wr = is_sw;
      dec_store  = is_sw ? rt_val : '0;
    end
  end

  // ID/EX register
  logic        ex_valid_q, ex_valid_d;
  logic [31:0] ex_op1_q, ex_op1_d;
  logic [31:0] ex_op2_q, ex_op2_d;
  logic [5:0]  ex_opcode_q, ex_opcode_d;
  logic [5:0]  ex_ar_op_q, ex_ar_op_d;
  logic [4:0]  ex_shamt_q, ex_shamt_d;
  logic [4:0]  ex_rd_q, ex_rd_d;
  logic        ex_wr_en_q, ex_wr_en_d;
  logic        ex_mem_rd_q, ex_mem_rd_d;
  logic        ex_mem_wr_q, ex_mem_wr_d;
  logic [31:0] ex_store_q, ex_store_d;
  logic        jr_taken_q, jr_taken_d;
  logic [31:0] jr_target_q, jr_target_d;
  logic        illegal_q, illegal_d;
  logic [1:0]  bub_cnt_q, bub_cnt_d;

  logic stall_out, hazard, transfer;

  assign stall_out = ex_valid_q & ~ex_ready;
  assign hazard    = ex_valid_q & ex_mem_rd_q & (ex_rd_q != '0) & if_valid &
                     ((ex_rd_q == f_rs) | ((is_addu | is_sw) & (ex_rd_q == f_rt)));
  // rst_n gating keeps if_ready low while reset is held
  assign if_ready  = rst_n & ~stall_out & ~hazard & (bub_cnt_q == '0);
  assign transfer  = if_valid & if_ready;

  always_comb begin
    ex_valid_d  = ex_valid_q;
    ex_op1_d    = ex_op1_q;
    ex_op2_d    = ex_op2_q;
    ex_opcode_d = ex_opcode_q;
    ex_ar_op_d  = ex_ar_op_q;
    ex_shamt_d  = ex_shamt_q;
    ex_rd_d     = ex_rd_q;
    ex_wr_en_d  = ex_wr_en_q;
    ex_mem_rd_d = ex_mem_rd_q;
    ex_mem_wr_d = ex_mem_wr_q;
    ex_store_d  = ex_store_q;
    jr_target_d = jr_target_q;
    jr_taken_d  = 1'b0;
    illegal_d   = 1'b0;
    bub_cnt_d   = bub_cnt_q;

    if (!stall_out) begin
      if (transfer) begin
`ifdef DECODE_ILLEGAL_TRAP_EN
        if (!is_legal) begin
          ex_valid_d = 1'b0;
          illegal_d  = 1'b1;
        end else begin
`else
        begin
`endif
          ex_valid_d  = 1'b1;
          ex_op1_d    = dec_op1;
          ex_op2_d    = dec_op2;
          ex_opcode_d = dec_opcode;
          ex_ar_op_d  = dec_ar_op;
          ex_shamt_d  = dec_shamt;
          ex_rd_d     = dec_rd;
          ex_wr_en_d  = dec_wr_en;
          ex_mem_rd_d = dec_mem_rd;
          ex_mem_wr_d = dec_mem_wr;
          ex_store_d  = dec_store;
          jr_taken_d  = is_jr;
          if (is_jr) begin
            jr_target_d = rs_val;
          end
        end
      end else begin
        ex_valid_d = 1'b0;
      end
    end

    // The hazard cycle itself is the first bubble; the counter covers the rest.
    if (bub_cnt_q != '0) begin
      bub_cnt_d = bub_cnt_q - 2'd1;
    end else if (hazard && ex_ready) begin
      bub_cnt_d = BUB_LOAD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q  <= 1'b0;
      ex_op1_q    <= '0;
      ex_op2_q    <= '0;
      ex_opcode_q <= '0;
      ex_ar_op_q  <= '0;
      ex_shamt_q  <= '0;
      ex_rd_q     <= '0;
      ex_wr_en_q  <= 1'b0;
      ex_mem_rd_q <= 1'b0;
      ex_mem_wr_q <= 1'b0;
      ex_store_q  <= '0;
      jr_taken_q  <= 1'b0;
      jr_target_q <= '0;
      illegal_q   <= 1'b0;
      bub_cnt_q   <= '0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_op1_q    <= ex_op1_d;
      ex_op2_q    <= ex_op2_d;
      ex_opcode_q <= ex_opcode_d;
      ex_ar_op_q  <= ex_ar_op_d;
      ex_shamt_q  <= ex_shamt_d;
      ex_rd_q     <= ex_rd_d;
      ex_wr_en_q  <= ex_wr_en_d;
      ex_mem_rd_q <= ex_mem_rd_d;
      ex_mem_wr_q <= ex_mem_wr_d;
      ex_store_q  <= ex_store_d;
      jr_taken_q  <= jr_taken_d;
      jr_target_q <= jr_target_d;
      illegal_q   <= illegal_d;
      bub_cnt_q   <= bub_cnt_d;
    end
  end

  assign ex_valid      = ex_valid_q;
  assign ex_op1        = ex_op1_q;
  assign ex_op2        = ex_op2_q;
  assign ex_opcode     = ex_opcode_q;
  assign ex_ar_op      = ex_ar_op_q;
  assign ex_shamt      = ex_shamt_q;
  assign ex_rd         = ex_rd_q;
  assign ex_wr_en      = ex_wr_en_q;
  assign ex_mem_rd     = ex_mem_rd_q;
  assign ex_mem_wr     = ex_mem_wr_q;
  assign ex_store_data = ex_store_q;
  assign jr_taken      = jr_taken_q;
  assign jr_target     = jr_target_q;

`ifdef DECODE_ILLEGAL_TRAP_EN
  assign illegal = illegal_q;
`else
  // Without the trap there is no output for this flop; it stays at zero.
  logic unused_illegal;
  assign unused_illegal = illegal_q;
`endif

endmodule
